// File: rtl/nb_force_accumulator.sv
// Per-slot neighbour force accumulator with a registered-head output FIFO.
// A release pushes {sum, pair count, parid} to the FIFO and clears the selected slot.
module nb_force_accumulator #(
    parameter int NUM_FILTERS       = 6,
    parameter int FORCE_WIDTH       = 32,
    parameter int PARTICLE_ID_WIDTH = 9,
    parameter int CNT_WIDTH         = 8,
    parameter int OUT_FIFO_DEPTH    = 8,
    parameter int BP_MARGIN         = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3*FORCE_WIDTH-1:0]     i_force,
    input  logic                         i_force_valid,
    input  logic [NUM_FILTERS-1:0]       i_acc_reg_select,
    input  logic [PARTICLE_ID_WIDTH-1:0] i_nb_parid,
    input  logic                         i_release_flag,
    output logic [3*FORCE_WIDTH-1:0]     o_nb_force,
    output logic [PARTICLE_ID_WIDTH-1:0] o_nb_parid,
    output logic [CNT_WIDTH-1:0]         o_nb_pair_cnt,
    output logic                         o_nb_force_valid,
    input  logic                         i_nb_force_ready,
    output logic                         o_back_pressure,
    output logic                         o_error
);
    localparam int FW = FORCE_WIDTH;
    localparam int SW = 3 * FW;
    localparam int IW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int AW = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = SW + CNT_WIDTH + PARTICLE_ID_WIDTH;

    function automatic logic [FW-1:0] sat_add(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [FW:0] s;
        s = {a[FW-1], a} + {b[FW-1], b};
        if (s[FW] != s[FW-1])
            sat_add = s[FW] ? {1'b1, {(FW-1){1'b0}}} : {1'b0, {(FW-1){1'b1}}};
        else
            sat_add = s[FW-1:0];
    endfunction

    logic [NUM_FILTERS-1:0][SW-1:0]                sum_q;
    logic [NUM_FILTERS-1:0][CNT_WIDTH-1:0]         cnt_q;
    logic [NUM_FILTERS-1:0][PARTICLE_ID_WIDTH-1:0] parid_q;

    logic                 evt, onehot, take, wr_req;
    logic [IW-1:0]        idx;
    logic [SW-1:0]        acc_sum;
    logic [CNT_WIDTH-1:0] acc_cnt;
    logic [EW-1:0]        entry;

    always_comb begin
        evt    = i_force_valid | i_release_flag;
        onehot = $onehot(i_acc_reg_select);
        take   = evt & onehot;
        idx    = '0;
        for (int j = 0; j < NUM_FILTERS; j++)
            if (i_acc_reg_select[j]) idx = IW'(j);
        acc_sum = '0;
        for (int k = 0; k < 3; k++)
            acc_sum[k*FW +: FW] = sat_add(sum_q[idx][k*FW +: FW], i_force[k*FW +: FW]);
        acc_cnt = (&cnt_q[idx]) ? cnt_q[idx] : cnt_q[idx] + 1'b1;
        // A release without force only produces an entry if the slot saw at least one pair.
        if (i_force_valid) begin
            entry  = {acc_sum, acc_cnt, i_nb_parid};
            wr_req = take & i_release_flag;
        end else begin
            entry  = {sum_q[idx], cnt_q[idx], parid_q[idx]};
            wr_req = take & i_release_flag & (cnt_q[idx] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            cnt_q   <= '0;
            parid_q <= '0;
        end else if (take) begin
            for (int j = 0; j < NUM_FILTERS; j++) begin
                if (i_acc_reg_select[j]) begin
                    if (i_release_flag) begin
                        sum_q[j]   <= '0;
                        cnt_q[j]   <= '0;
                        parid_q[j] <= '0;
                    end else begin
                        sum_q[j]   <= acc_sum;
                        cnt_q[j]   <= acc_cnt;
                        parid_q[j] <= i_nb_parid;
                    end
                end
            end
        end
    end

    // Output FIFO: count includes the entry currently presented at the head register.
    logic [EW-1:0] mem [OUT_FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, rd_idx;
    logic [CW-1:0] count, count_nxt, free_nxt;
    logic [EW-1:0] head_q;
    logic          head_vld, pop, full, do_wr, ovf, vis_nxt;

    always_comb begin
        pop       = head_vld & i_nb_force_ready;
        full      = (count == CW'(OUT_FIFO_DEPTH));
        do_wr     = wr_req & (~full | pop);
        ovf       = wr_req & full & ~pop;
        count_nxt = count + CW'(do_wr) - CW'(pop);
        free_nxt  = CW'(OUT_FIFO_DEPTH) - count_nxt;
        rd_idx    = rptr + AW'(pop);
        // Entries written on this edge become visible one edge later.
        vis_nxt   = (count - CW'(pop)) != '0;
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr            <= '0;
            rptr            <= '0;
            count           <= '0;
            head_vld        <= 1'b0;
            head_q          <= '0;
            o_back_pressure <= 1'b0;
            o_error         <= 1'b0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            count    <= count_nxt;
            head_vld <= vis_nxt;
            if (vis_nxt) head_q <= mem[rd_idx];
            o_back_pressure <= (free_nxt <= CW'(BP_MARGIN));
            o_error  <= o_error | (evt & ~onehot) | ovf;
        end
    end

    assign o_nb_force_valid = head_vld;
    assign {o_nb_force, o_nb_pair_cnt, o_nb_parid} = head_q;
endmodule

// File: tb/tb_nb_force_accumulator.sv
// Randomized and directed bench for nb_force_accumulator against a queue-based reference model.
module tb_nb_force_accumulator;
    localparam int NF = 6, FW = 32, PW = 9, CNW = 8, DEPTH = 8, BPM = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3*FW-1:0] i_force = '0;
    logic            i_force_valid = 1'b0;
    logic [NF-1:0]   i_acc_reg_select = '0;
    logic [PW-1:0]   i_nb_parid = '0;
    logic            i_release_flag = 1'b0;
    logic [3*FW-1:0] o_nb_force;
    logic [PW-1:0]   o_nb_parid;
    logic [CNW-1:0]  o_nb_pair_cnt;
    logic            o_nb_force_valid;
    logic            i_nb_force_ready = 1'b1;
    logic            o_back_pressure;
    logic            o_error;

    nb_force_accumulator #(
        .NUM_FILTERS(NF), .FORCE_WIDTH(FW), .PARTICLE_ID_WIDTH(PW),
        .CNT_WIDTH(CNW), .OUT_FIFO_DEPTH(DEPTH), .BP_MARGIN(BPM)
    ) dut (
        .clk(clk), .rst(rst), .i_force(i_force), .i_force_valid(i_force_valid),
        .i_acc_reg_select(i_acc_reg_select), .i_nb_parid(i_nb_parid),
        .i_release_flag(i_release_flag), .o_nb_force(o_nb_force), .o_nb_parid(o_nb_parid),
        .o_nb_pair_cnt(o_nb_pair_cnt), .o_nb_force_valid(o_nb_force_valid),
        .i_nb_force_ready(i_nb_force_ready), .o_back_pressure(o_back_pressure), .o_error(o_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint f[3];
        int     cnt;
        int     pid;
    } ent_t;

    longint msum[NF][3];
    int     mcnt[NF];
    int     mpid[NF];
    ent_t   q[$];
    bit     mvld, mbp, merr;
    int     n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd2147483647) return 64'sd2147483647;
        if (v < -64'sd2147483648) return -64'sd2147483648;
        return v;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < NF; s++) begin
            for (int k = 0; k < 3; k++) msum[s][k] = 0;
            mcnt[s] = 0;
            mpid[s] = 0;
        end
        q.delete();
        mvld = 0; mbp = 0; merr = 0;
    endtask

    // Reference behaviour for one rising edge, using the inputs currently applied.
    task automatic model_edge();
        bit     evt, pop, wr;
        int     s;
        ent_t   e;
        longint nsum[3];
        logic [31:0] c;
        pop = mvld && i_nb_force_ready;
        evt = i_force_valid || i_release_flag;
        wr  = 0;
        s   = 0;
        for (int j = 0; j < NF; j++) if (i_acc_reg_select[j]) s = j;
        if (evt && $countones(i_acc_reg_select) != 1) merr = 1;
        else if (evt) begin
            if (i_force_valid) begin
                for (int k = 0; k < 3; k++) begin
                    c = i_force[k*32 +: 32];
                    nsum[k] = sat(msum[s][k] + longint'($signed(c)));
                end
                if (i_release_flag) begin
                    for (int k = 0; k < 3; k++) e.f[k] = nsum[k];
                    e.cnt = (mcnt[s] < 255) ? mcnt[s] + 1 : 255;
                    e.pid = int'(i_nb_parid);
                    wr = 1;
                end else begin
                    for (int k = 0; k < 3; k++) msum[s][k] = nsum[k];
                    mcnt[s] = (mcnt[s] < 255) ? mcnt[s] + 1 : 255;
                    mpid[s] = int'(i_nb_parid);
                end
            end else if (mcnt[s] != 0) begin
                for (int k = 0; k < 3; k++) e.f[k] = msum[s][k];
                e.cnt = mcnt[s];
                e.pid = mpid[s];
                wr = 1;
            end
            if (i_release_flag) begin
                for (int k = 0; k < 3; k++) msum[s][k] = 0;
                mcnt[s] = 0;
                mpid[s] = 0;
            end
        end
        if (pop) void'(q.pop_front());
        mvld = q.size() != 0;
        if (wr) begin
            if (q.size() < DEPTH) q.push_back(e);
            else merr = 1;
        end
        mbp = (DEPTH - q.size()) <= BPM;
    endtask

    task automatic cyc();
        logic [95:0] ef;
        longint t;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("valid", o_nb_force_valid, mvld);
        chk("back_pressure", o_back_pressure, mbp);
        chk("error", o_error, merr);
        if (mvld) begin
            for (int k = 0; k < 3; k++) begin
                t = q[0].f[k];
                ef[k*32 +: 32] = t[31:0];
            end
            chk("head_force", o_nb_force, ef);
            chk("head_cnt", o_nb_pair_cnt, q[0].cnt);
            chk("head_parid", o_nb_parid, q[0].pid);
        end
    endtask

    task automatic drv(input bit fv, input bit rel, input logic [NF-1:0] s, input int pid,
                       input logic [31:0] fx, input logic [31:0] fy, input logic [31:0] fz,
                       input bit rdy);
        i_force_valid    = fv;
        i_release_flag   = rel;
        i_acc_reg_select = s;
        i_nb_parid       = PW'(pid);
        i_force          = {fz, fy, fx};
        i_nb_force_ready = rdy;
        cyc();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drv(0, 0, '0, 0, 0, 0, 0, rdy);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, o_nb_force_valid, 0);
        chk({tag, "_force"}, o_nb_force, 0);
        chk({tag, "_parid"}, o_nb_parid, 0);
        chk({tag, "_cnt"}, o_nb_pair_cnt, 0);
        chk({tag, "_bp"}, o_back_pressure, 0);
        chk({tag, "_error"}, o_error, 0);
    endtask

    task automatic async_reset();
        #2 rst = 1'b1;
        #1 chk_zero_outputs("async_rst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        #12 chk_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1);

        // single slot accumulation, third pair carries the release
        drv(1, 0, 6'h01, 17, 1, 2, 3, 1);
        drv(1, 0, 6'h01, 17, 4, 5, 6, 1);
        drv(1, 1, 6'h01, 17, -2, 0, 7, 1);
        idle(3, 1);
        drv(1, 1, 6'h01, 3, 1, 1, 1, 1);
        idle(3, 1);

        // interleaved slots
        for (int i = 0; i < 8; i++) drv(1, 0, (i % 2) ? 6'h04 : 6'h01, 20 + (i % 2), 1, 1, 1, 1);
        drv(0, 1, 6'h04, 0, 0, 0, 0, 1);
        drv(0, 1, 6'h01, 0, 0, 0, 0, 1);
        idle(3, 1);

        // release without force, then release of the emptied slot
        drv(1, 0, 6'h02, 33, 5, 5, 5, 1);
        drv(1, 0, 6'h02, 33, 5, 5, 5, 1);
        drv(0, 1, 6'h02, 0, 0, 0, 0, 1);
        drv(0, 1, 6'h02, 0, 0, 0, 0, 1);
        idle(3, 1);

        // positive and negative saturation
        drv(1, 0, 6'h08, 7, 32'h7FFFFFF0, 0, 0, 1);
        drv(1, 1, 6'h08, 7, 32'h00000100, 0, 0, 1);
        drv(1, 0, 6'h08, 8, 32'h80000010, 32'h80000000, 0, 1);
        drv(1, 1, 6'h08, 8, 32'hFFFFFF00, 32'hFFFFFFFF, 0, 1);
        idle(3, 1);

        // back pressure and overflow with the consumer stalled
        for (int i = 0; i < 9; i++) drv(1, 1, 6'h10, 100 + i, i, 2 * i, -i, 0);
        idle(3, 0);
        idle(12, 1);

        // asynchronous reset mid-accumulation, then a bad select
        drv(1, 0, 6'h01, 40, 9, 9, 9, 1);
        drv(1, 0, 6'h20, 41, 3, 3, 3, 1);
        async_reset();
        drv(1, 0, 6'h01, 42, 2, 2, 2, 1);
        drv(1, 0, 6'h03, 43, 50, 50, 50, 1);
        drv(1, 1, 6'h01, 42, 1, 1, 1, 1);
        drv(0, 1, 6'h20, 0, 0, 0, 0, 1);
        idle(3, 1);
        async_reset();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [NF-1:0] s;
            logic [31:0]   f[3];
            s = NF'(1 << $urandom_range(0, NF - 1));
            if ($urandom_range(0, 99) < 3) s = NF'($urandom_range(0, 63));
            for (int k = 0; k < 3; k++)
                f[k] = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
            drv($urandom_range(0, 1), $urandom_range(0, 3) == 0, s, $urandom_range(0, 511),
                f[0], f[1], f[2], $urandom_range(0, 2) != 0);
        end
        idle(12, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/nb_force_accumulator.md
Name: nb_force_accumulator

Overview:
- Sits downstream of the filter dispatcher and the force evaluation pipeline.
- Keeps one partial-force accumulator per filter neighbour register and adds each evaluated pair force into the slot selected by the delayed accumulator select.
- When the dispatcher's release flag reaches this stage, the finished neighbour force is written into a small output FIFO, and the slot is cleared for the next neighbour particle.
- The FIFO is drained by the force write-back stage using a valid/ready handshake.

Parameters:
- NUM_FILTERS, 6, number of filter slots; width of the one-hot select.
- FORCE_WIDTH, 32, width of each signed two's-complement fixed-point force component.
- PARTICLE_ID_WIDTH, 9, neighbour particle id width.
- CNT_WIDTH, 8, per-slot pair counter width; the counter saturates at its maximum.
- OUT_FIFO_DEPTH, 8, output FIFO depth; must be a power of 2.
- BP_MARGIN, 2, free FIFO entries at or below which o_back_pressure asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_force  in  3*FORCE_WIDTH  {fz,fy,fx} force on the neighbour for this pair
- i_force_valid  in  1  pair force valid
- i_acc_reg_select  in  NUM_FILTERS  one-hot slot select, aligned with i_force_valid and i_release_flag
- i_nb_parid  in  PARTICLE_ID_WIDTH  neighbour particle id for this pair/slot
- i_release_flag  in  1  selected slot's neighbour has finished; may occur with or without i_force_valid
- o_nb_force  out  3*FORCE_WIDTH  accumulated neighbour force at FIFO head
- o_nb_parid  out  PARTICLE_ID_WIDTH  neighbour id at FIFO head
- o_nb_pair_cnt  out  CNT_WIDTH  number of pairs accumulated
- o_nb_force_valid  out  1  FIFO head valid
- i_nb_force_ready  in  1  consumer accepts head when valid && ready
- o_back_pressure  out  1  FIFO free entries <= BP_MARGIN
- o_error  out  1  sticky error flag: overflow or non-one-hot select

Behaviour:
- Reset (asynchronous, any time, including mid-accumulation):
  - all slot sums, counts, parids and FIFO pointers go to 0.
  - o_nb_force_valid=0, o_nb_force=0, o_nb_parid=0, o_nb_pair_cnt=0, o_back_pressure=0, o_error=0.
  - In-flight partial sums are discarded.
- Event qualification:
  - An event is sampled on a rising edge when i_force_valid or i_release_flag is high.
  - If i_acc_reg_select is not one-hot (zero or more than one bit set), the event is ignored and o_error is set.
- Accumulate (valid=1, release=0), slot s:
  - sum[s] += i_force, per component, saturating to [-2^(FORCE_WIDTH-1), 2^(FORCE_WIDTH-1)-1].
  - cnt[s] += 1, saturating at its maximum.
  - parid[s] <= i_nb_parid.
- Release with force (valid=1, release=1):
  - The FIFO entry is {sum[s]+i_force (saturated), cnt[s]+1, i_nb_parid}.
  - Slot s clears to 0 on the same edge.
- Release without force (valid=0, release=1):
  - If cnt[s]!=0, the FIFO entry is {sum[s], cnt[s], parid[s]}.
  - If cnt[s]==0, nothing is written.
  - Slot s clears in both cases.
- Slot independence: only slot s is touched. Other slots keep their values every cycle.
- Latency:
  - The FIFO write occurs on the sampling edge N.
  - With an empty FIFO, o_nb_force_valid goes high after edge N+1; the head is registered for timing.
  - Throughput is one release per cycle.
- FIFO behaviour:
  - Simultaneous write and pop are allowed. Occupancy is unchanged and the pointers wrap modulo OUT_FIFO_DEPTH.
  - Head outputs are held stable while valid && !ready.
- Overflow:
  - A release needing a write while the FIFO is full (with no pop on that edge) drops the entry and sets o_error.
  - The slot still clears.
  - The upstream dispatcher must stall on o_back_pressure to avoid this.
- o_back_pressure is registered and is computed from occupancy after the edge.
- o_error clears only on rst.

Test Plan:
- Single slot accumulation:
  - Stimulus: slot 0x01, parid 17, forces (1,2,3), (4,5,6), (-2,0,7); the third arrives with release.
  - Required response: one output {3,7,16}, cnt=3, parid=17, valid two edges after the release; slot 0 then reads 0.
- Interleaved slots:
  - Stimulus: alternating 0x01/0x04 each cycle, 4 forces each of (1,1,1), then release slot 0x04 alone and then slot 0x01 alone.
  - Required response: two outputs, in release order, each {4,4,4} cnt=4; no cross-slot contamination.
- Release without force:
  - Stimulus: slot 0x02 with cnt=2, sum (10,10,10), released with valid=0.
  - Required response: output {10,10,10}, cnt=2.
  - Stimulus: a second release on the now-empty slot 0x02.
  - Required response: no output.
- Saturation:
  - Stimulus: FORCE_WIDTH=32, add fx=0x7FFFFFF0 then fx=0x100.
  - Required response: fx=0x7FFFFFFF.
  - Stimulus: negative analogue.
  - Required response: 0x80000000.
- Backpressure and overflow:
  - Stimulus: hold ready=0 and issue 9 releases, one per cycle.
  - Required response: o_back_pressure high once 6 entries are stored; 9th dropped; o_error=1.
  - Stimulus: then ready=1.
  - Required response: 8 entries drain in order with stable heads.
- Error and reset:
  - Stimulus: select 0x03 with valid.
  - Required response: o_error=1, no slot changes.
  - Stimulus: assert rst asynchronously mid-accumulation.
  - Required response: all outputs 0 immediately; post-reset accumulation starts from 0.
